// File: rtl/frame_sched_pkg.sv
`default_nettype none
// ============================================================================
// Module      : frame_sched_pkg
// Description : Shared definitions for the LED frame scheduler: state
//               encodings, default counter widths and the FIFO-empty
//               debounce length used to detect a short frame.
// Revision    : 1.0 - initial release
// ============================================================================
package frame_sched_pkg;

    localparam int LVL_W_DEF      = 11;
    localparam int TMO_W_DEF      = 16;
    localparam int FCNT_W_DEF     = 8;

    // Consecutive FIFO_EMPTY cycles in RUNNING that end a frame early.
    localparam int EMPTY_DEBOUNCE = 2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FILL = 2'd1,
        ST_RUN  = 2'd2,
        ST_EOF  = 2'd3
    } state_t;

endpackage : frame_sched_pkg
`default_nettype wire

// File: rtl/frame_sched_level.sv
`default_nettype none
// ============================================================================
// Module      : fifo_level_tracker
// Description : Saturating up/down counter that mirrors FIFO occupancy from
//               qualified write/read strobes.
// Ports       : clk     - system clock
//               rst     - synchronous active-high clear
//               i_inc   - qualified write (WE & ~FULL)
//               i_dec   - qualified read  (RE & ~EMPTY)
//               o_level - registered occupancy
// Revision    : 1.0 - initial release
// ============================================================================
module fifo_level_tracker #(
    parameter int LVL_W = 11
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_inc,
    input  logic             i_dec,
    output logic [LVL_W-1:0] o_level
);

    logic [LVL_W-1:0] r_level;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_level <= '0;
        end else if (i_inc && !i_dec) begin
            if (r_level != {LVL_W{1'b1}}) begin
                r_level <= r_level + LVL_W'(1);
            end
        end else if (i_dec && !i_inc) begin
            if (r_level != '0) begin
                r_level <= r_level - LVL_W'(1);
            end
        end
    end

    assign o_level = r_level;

endmodule : fifo_level_tracker
`default_nettype wire

// File: rtl/frame_sched.sv
`default_nettype none
// ============================================================================
// Module      : frame_sched
// Description : Frame scheduler between the LED FIFO, the serializer and the
//               register block. Starts a frame on full fill, software request
//               or fill timeout, drives RUN, waits for the serializer's
//               end-of-frame pulse and re-arms.
// Ports       : CLK/RST      - clock, synchronous active-high reset
//               ENABLE       - 0 clears all state (same as RST)
//               AUTO         - allow fill/timeout starts
//               SW_RUN       - one-cycle software start
//               FRAME_LEN    - pixels per frame (0 treated as 1)
//               TIMEOUT      - fill timeout in cycles (0 disables)
//               FIFO_*       - FIFO strobes and flags
//               SER_EOF      - serializer reset-code-complete pulse
//               RUN/BUSY     - serializer run level / not idle
//               LEVEL        - tracked FIFO occupancy
//               FRAME_CNT    - completed frames (wraps)
//               PARTIAL/SHORT- sticky status flags
// Revision    : 1.0 - initial release
// ============================================================================
module frame_sched
    import frame_sched_pkg::*;
#(
    parameter int LVL_W  = LVL_W_DEF,
    parameter int TMO_W  = TMO_W_DEF,
    parameter int FCNT_W = FCNT_W_DEF
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              ENABLE,
    input  logic              AUTO,
    input  logic              SW_RUN,
    input  logic [LVL_W-1:0]  FRAME_LEN,
    input  logic [TMO_W-1:0]  TIMEOUT,
    input  logic              FIFO_WE,
    input  logic              FIFO_FULL,
    input  logic              FIFO_RE,
    input  logic              FIFO_EMPTY,
    input  logic              SER_EOF,
    output logic              RUN,
    output logic              BUSY,
    output logic [LVL_W-1:0]  LEVEL,
    output logic [FCNT_W-1:0] FRAME_CNT,
    output logic              PARTIAL,
    output logic              SHORT
);

    localparam logic [1:0] c_EMPTY_LAST = 2'(EMPTY_DEBOUNCE - 1);

    state_t            r_state;
    state_t            w_next;
    logic [TMO_W-1:0]  r_tmo;
    logic [LVL_W-1:0]  r_pix_cnt;
    logic [LVL_W-1:0]  r_pix_target;
    logic [1:0]        r_empty_cnt;
    logic              r_run;
    logic [FCNT_W-1:0] r_fcnt;
    logic              r_partial;
    logic              r_short;

    logic              w_clr;
    logic              w_inc;
    logic              w_dec;
    logic [LVL_W-1:0]  w_level;
    logic              w_lvl_nz;
    logic [LVL_W-1:0]  w_eff_len;
    logic              w_fill_hit;
    logic              w_tmo_hit;
    logic [LVL_W-1:0]  w_pix_next;
    logic              w_empty_hit;
    logic              w_set_partial;
    logic              w_set_short;
    logic              w_fcnt_inc;

    // The FIFO itself is held in reset by ~ENABLE, so occupancy clears too.
    assign w_clr = RST || !ENABLE;
    assign w_inc = FIFO_WE && !FIFO_FULL;
    assign w_dec = FIFO_RE && !FIFO_EMPTY;

    fifo_level_tracker #(
        .LVL_W (LVL_W)
    ) u_level (
        .clk     (CLK),
        .rst     (w_clr),
        .i_inc   (w_inc),
        .i_dec   (w_dec),
        .o_level (w_level)
    );

    assign w_lvl_nz    = (w_level != '0);
    assign w_eff_len   = (FRAME_LEN == '0) ? LVL_W'(1) : FRAME_LEN;
    assign w_fill_hit  = AUTO && (w_level >= w_eff_len);
    assign w_tmo_hit   = AUTO && (TIMEOUT != '0) && (r_tmo == (TIMEOUT - TMO_W'(1))) && w_lvl_nz;
    assign w_pix_next  = r_pix_cnt + LVL_W'(w_dec);
    assign w_empty_hit = FIFO_EMPTY && (r_empty_cnt == c_EMPTY_LAST);

    always_comb begin
        w_next        = r_state;
        w_set_partial = 1'b0;
        w_set_short   = 1'b0;
        w_fcnt_inc    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_lvl_nz || SW_RUN) begin
                    w_next = ST_FILL;
                end
            end
            ST_FILL: begin
                // Software start wins, then a full frame, then the timeout.
                if (SW_RUN || w_fill_hit) begin
                    w_next = ST_RUN;
                end else if (w_tmo_hit) begin
                    w_next        = ST_RUN;
                    w_set_partial = (w_level < w_eff_len);
                end
            end
            ST_RUN: begin
                if (w_pix_next >= r_pix_target) begin
                    w_next = ST_EOF;
                end else if (w_empty_hit) begin
                    w_next      = ST_EOF;
                    w_set_short = 1'b1;
                end
            end
            ST_EOF: begin
                if (SER_EOF) begin
                    w_fcnt_inc = 1'b1;
                    w_next     = w_lvl_nz ? ST_FILL : ST_IDLE;
                end
            end
            default: w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (w_clr) begin
            r_state      <= ST_IDLE;
            r_tmo        <= '0;
            r_pix_cnt    <= '0;
            r_pix_target <= '0;
            r_empty_cnt  <= '0;
            r_run        <= 1'b0;
            r_fcnt       <= '0;
            r_partial    <= 1'b0;
            r_short      <= 1'b0;
        end else begin
            r_state <= w_next;

            // Timeout counts only cycles spent waiting with data present.
            if (r_state != ST_FILL && w_next == ST_FILL) begin
                r_tmo <= '0;
            end else if (r_state == ST_FILL && w_lvl_nz && r_tmo != {TMO_W{1'b1}}) begin
                r_tmo <= r_tmo + TMO_W'(1);
            end

            // Frame length is frozen at frame start.
            if (r_state != ST_RUN && w_next == ST_RUN) begin
                r_pix_target <= w_eff_len;
                r_pix_cnt    <= '0;
            end else if (r_state == ST_RUN) begin
                r_pix_cnt <= w_pix_next;
            end

            if (r_state == ST_RUN && w_next == ST_RUN && FIFO_EMPTY) begin
                if (r_empty_cnt != c_EMPTY_LAST) begin
                    r_empty_cnt <= r_empty_cnt + 2'd1;
                end
            end else begin
                r_empty_cnt <= '0;
            end

            // RUN follows the state one cycle late on entry, drops with the exit.
            r_run <= (r_state == ST_RUN) && (w_next == ST_RUN);

            if (w_fcnt_inc) begin
                r_fcnt <= r_fcnt + FCNT_W'(1);
            end
            if (w_set_partial) begin
                r_partial <= 1'b1;
            end
            if (w_set_short) begin
                r_short <= 1'b1;
            end
        end
    end

    assign RUN       = r_run;
    assign BUSY      = (r_state != ST_IDLE);
    assign LEVEL     = w_level;
    assign FRAME_CNT = r_fcnt;
    assign PARTIAL   = r_partial;
    assign SHORT     = r_short;

endmodule : frame_sched
`default_nettype wire

// File: tb/tb_frame_sched.sv
`default_nettype none
// ============================================================================
// Module      : tb_frame_sched
// Description : Directed self-checking bench for frame_sched. Inputs are
//               driven and outputs sampled on the falling clock edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_frame_sched;

    logic        CLK = 1'b0;
    logic        RST, ENABLE, AUTO, SW_RUN;
    logic [10:0] FRAME_LEN;
    logic [15:0] TIMEOUT;
    logic        FIFO_WE, FIFO_FULL, FIFO_RE, FIFO_EMPTY, SER_EOF;
    logic        RUN, BUSY, PARTIAL, SHORT;
    logic [10:0] LEVEL;
    logic [7:0]  FRAME_CNT;

    // Serializer/FIFO stand-ins: reads follow RUN, empty follows LEVEL,
    // unless a step overrides them.
    logic re_auto, re_man, empty_auto, empty_ovr;
    assign FIFO_RE    = re_auto ? RUN : re_man;
    assign FIFO_EMPTY = empty_auto ? (LEVEL == 11'd0) : empty_ovr;

    int tests = 0;
    int fails = 0;
    int rd_total = 0;
    int rd_base;
    bit saw_run;

    frame_sched u_dut (
        .CLK        (CLK),
        .RST        (RST),
        .ENABLE     (ENABLE),
        .AUTO       (AUTO),
        .SW_RUN     (SW_RUN),
        .FRAME_LEN  (FRAME_LEN),
        .TIMEOUT    (TIMEOUT),
        .FIFO_WE    (FIFO_WE),
        .FIFO_FULL  (FIFO_FULL),
        .FIFO_RE    (FIFO_RE),
        .FIFO_EMPTY (FIFO_EMPTY),
        .SER_EOF    (SER_EOF),
        .RUN        (RUN),
        .BUSY       (BUSY),
        .LEVEL      (LEVEL),
        .FRAME_CNT  (FRAME_CNT),
        .PARTIAL    (PARTIAL),
        .SHORT      (SHORT)
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK) begin
        if (FIFO_RE && !FIFO_EMPTY) rd_total++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic wait_run(input logic val, input string tag);
        int n = 0;
        while (RUN !== val && n < 400) begin
            @(negedge CLK);
            n++;
        end
        check(tag, {31'd0, RUN}, {31'd0, val});
    endtask

    task automatic pulse_eof();
        SER_EOF = 1'b1;
        @(negedge CLK);
        SER_EOF = 1'b0;
    endtask

    task automatic pulse_sw();
        SW_RUN = 1'b1;
        @(negedge CLK);
        SW_RUN = 1'b0;
    endtask

    task automatic write_n(input int n);
        for (int i = 0; i < n; i++) begin
            FIFO_WE = 1'b1;
            @(negedge CLK);
        end
        FIFO_WE = 1'b0;
    endtask

    // Frame with an empty FIFO: two SW_RUN cycles reach RUNNING from IDLE
    // (or FILL), the empty debounce ends it, then SER_EOF closes it.
    task automatic zero_frame();
        SW_RUN = 1'b1;
        @(negedge CLK);
        @(negedge CLK);
        SW_RUN = 1'b0;
        repeat (2) @(negedge CLK);
        pulse_eof();
    endtask

    initial begin
        RST = 1'b1; ENABLE = 1'b1; AUTO = 1'b1; SW_RUN = 1'b0;
        FRAME_LEN = 11'd4; TIMEOUT = 16'd0;
        FIFO_WE = 1'b0; FIFO_FULL = 1'b0; SER_EOF = 1'b0;
        re_auto = 1'b1; re_man = 1'b0; empty_auto = 1'b1; empty_ovr = 1'b1;
        repeat (3) @(negedge CLK);
        RST = 1'b0;
        @(negedge CLK);

        // Reset state
        check("rst_run",   {31'd0, RUN}, 0);
        check("rst_busy",  {31'd0, BUSY}, 0);
        check("rst_level", {21'd0, LEVEL}, 0);
        check("rst_fcnt",  {24'd0, FRAME_CNT}, 0);
        check("rst_flags", {30'd0, PARTIAL, SHORT}, 0);

        // 1: full-frame auto start, FRAME_LEN=4
        rd_base = rd_total;
        write_n(4);
        check("t1_level4", {21'd0, LEVEL}, 4);
        check("t1_run_n0", {31'd0, RUN}, 0);
        @(negedge CLK);
        check("t1_run_n1", {31'd0, RUN}, 0);
        check("t1_busy",   {31'd0, BUSY}, 1);
        @(negedge CLK);
        check("t1_run_n2", {31'd0, RUN}, 1);
        wait_run(1'b0, "t1_run_fall");
        check("t1_reads",  rd_total - rd_base, 4);
        check("t1_lvl0",   {21'd0, LEVEL}, 0);
        check("t1_weof",   {31'd0, BUSY}, 1);
        pulse_eof();
        check("t1_fcnt",   {24'd0, FRAME_CNT}, 1);
        check("t1_idle",   {31'd0, BUSY}, 0);
        check("t1_flags",  {30'd0, PARTIAL, SHORT}, 0);

        // 2: timeout start with 3 of 8 pixels. FILL is entered the cycle after
        // LEVEL first reads nonzero (k=0); tmo reaches 99 after 100 FILL edges,
        // so RUNNING is visible at k=101 and RUN at k=102.
        FRAME_LEN = 11'd8; TIMEOUT = 16'd100;
        rd_base = rd_total;
        FIFO_WE = 1'b1;
        @(negedge CLK);                       // k=0
        check("t2_lvl1", {21'd0, LEVEL}, 1);
        @(negedge CLK);                       // k=1
        @(negedge CLK);                       // k=2
        FIFO_WE = 1'b0;
        repeat (99) @(negedge CLK);           // k=101
        check("t2_run_k101", {31'd0, RUN}, 0);
        check("t2_busy",     {31'd0, BUSY}, 1);
        check("t2_partial",  {31'd0, PARTIAL}, 1);
        @(negedge CLK);                       // k=102
        check("t2_run_k102", {31'd0, RUN}, 1);
        wait_run(1'b0, "t2_run_fall");
        check("t2_reads", rd_total - rd_base, 3);
        check("t2_short", {31'd0, SHORT}, 1);
        check("t2_weof",  {31'd0, BUSY}, 1);
        pulse_eof();
        check("t2_fcnt",  {24'd0, FRAME_CNT}, 2);
        check("t2_idle",  {31'd0, BUSY}, 0);

        // 3: software start only
        AUTO = 1'b0; FRAME_LEN = 11'd4; TIMEOUT = 16'd0;
        write_n(10);
        check("t3_lvl10", {21'd0, LEVEL}, 10);
        saw_run = 1'b0;
        for (int i = 0; i < 500; i++) begin
            @(negedge CLK);
            if (RUN) saw_run = 1'b1;
        end
        check("t3_no_run", {31'd0, saw_run}, 0);
        rd_base = rd_total;
        pulse_sw();
        check("t3_run_n1", {31'd0, RUN}, 0);
        @(negedge CLK);
        check("t3_run_n2", {31'd0, RUN}, 1);
        wait_run(1'b0, "t3_run_fall");
        check("t3_reads", rd_total - rd_base, 4);
        pulse_eof();
        check("t3_level", {21'd0, LEVEL}, 6);
        check("t3_fill",  {31'd0, BUSY}, 1);
        check("t3_fcnt",  {24'd0, FRAME_CNT}, 3);

        // 4: occupancy corner cases (state stays FILL, AUTO=0)
        re_auto = 1'b0;
        re_man = 1'b1;
        @(negedge CLK);
        re_man = 1'b0;
        check("t4_lvl5", {21'd0, LEVEL}, 5);
        FIFO_WE = 1'b1; re_man = 1'b1;
        repeat (20) @(negedge CLK);
        FIFO_WE = 1'b0; re_man = 1'b0;
        check("t4_we_re", {21'd0, LEVEL}, 5);
        FIFO_FULL = 1'b1; FIFO_WE = 1'b1;
        @(negedge CLK);
        FIFO_FULL = 1'b0; FIFO_WE = 1'b0;
        check("t4_full", {21'd0, LEVEL}, 5);
        re_man = 1'b1;
        repeat (5) @(negedge CLK);
        re_man = 1'b0;
        check("t4_drain", {21'd0, LEVEL}, 0);
        empty_auto = 1'b0; empty_ovr = 1'b0; re_man = 1'b1;
        repeat (3) @(negedge CLK);
        re_man = 1'b0; empty_auto = 1'b1;
        check("t4_sat0", {21'd0, LEVEL}, 0);

        // 5: frame counter wrap, FRAME_LEN=0 behaves as 1
        for (int i = 0; i < 252; i++) zero_frame();
        check("t5_fcnt255", {24'd0, FRAME_CNT}, 255);
        re_auto = 1'b1; AUTO = 1'b1; FRAME_LEN = 11'd0;
        rd_base = rd_total;
        write_n(2);
        wait_run(1'b1, "t5_run_rise");
        wait_run(1'b0, "t5_run_fall");
        AUTO = 1'b0;
        check("t5_reads", rd_total - rd_base, 1);
        check("t5_level", {21'd0, LEVEL}, 1);
        pulse_eof();
        check("t5_wrap",  {24'd0, FRAME_CNT}, 0);
        check("t5_fill",  {31'd0, BUSY}, 1);

        // 6: ENABLE=0 mid-frame, then the same with RST
        FRAME_LEN = 11'd4;
        pulse_sw();                           // reads 1, then short frame
        wait_run(1'b1, "t6_pre_rise");
        wait_run(1'b0, "t6_pre_fall");
        pulse_eof();
        check("t6_pre_fcnt", {24'd0, FRAME_CNT}, 1);
        check("t6_pre_flags", {30'd0, PARTIAL, SHORT}, 3);
        re_auto = 1'b0;
        write_n(3);
        @(negedge CLK);
        pulse_sw();
        wait_run(1'b1, "t6_en_rise");
        ENABLE = 1'b0;
        @(negedge CLK);
        ENABLE = 1'b1;
        check("t6_en_run",   {31'd0, RUN}, 0);
        check("t6_en_level", {21'd0, LEVEL}, 0);
        check("t6_en_fcnt",  {24'd0, FRAME_CNT}, 0);
        check("t6_en_flags", {30'd0, PARTIAL, SHORT}, 0);
        check("t6_en_idle",  {31'd0, BUSY}, 0);

        zero_frame();
        check("t6_mid_fcnt", {24'd0, FRAME_CNT}, 1);
        write_n(3);
        @(negedge CLK);
        pulse_sw();
        wait_run(1'b1, "t6_rst_rise");
        RST = 1'b1;
        @(negedge CLK);
        RST = 1'b0;
        check("t6_rst_run",   {31'd0, RUN}, 0);
        check("t6_rst_level", {21'd0, LEVEL}, 0);
        check("t6_rst_fcnt",  {24'd0, FRAME_CNT}, 0);
        check("t6_rst_flags", {30'd0, PARTIAL, SHORT}, 0);
        check("t6_rst_idle",  {31'd0, BUSY}, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule : tb_frame_sched
`default_nettype wire

// File: doc/frame_sched.md
Name: frame_sched

Overview:
- Frame scheduler between the LED FIFO, the serializer and the register block.
- Tracks FIFO occupancy from write/read strobes and decides when the serializer may start a frame: on a full frame of pixels, on software request, or on a fill timeout with partial data.
- Drives the serializer RUN level, waits for end-of-frame (reset code complete), then re-arms.
- Reports frame count and status flags back to the registers.

Parameters:
- LVL_W, 11, occupancy/frame-length counter width; holds 0..1024 FIFO entries.
- TMO_W, 16, fill-timeout counter width.
- FCNT_W, 8, completed-frame counter width.

Ports:
- CLK  in  1  system clock (on-chip oscillator).
- RST  in  1  reset; synchronous, active-high.
- ENABLE  in  1  block enable from registers; 0 forces IDLE and clears all state.
- AUTO  in  1  1 = automatic start on frame fill or timeout; 0 = software start only.
- SW_RUN  in  1  single-cycle software start request.
- FRAME_LEN  in  LVL_W  pixels per frame; 0 is treated as 1.
- TIMEOUT  in  TMO_W  fill timeout in CLK cycles; 0 disables the timeout.
- FIFO_WE  in  1  FIFO write strobe from controller.
- FIFO_FULL  in  1  FIFO full flag.
- FIFO_RE  in  1  FIFO read strobe from serializer.
- FIFO_EMPTY  in  1  FIFO empty flag.
- SER_EOF  in  1  single-cycle pulse from serializer: reset code finished.
- RUN  out  1  serializer run level.
- BUSY  out  1  state is not IDLE.
- LEVEL  out  LVL_W  tracked FIFO occupancy.
- FRAME_CNT  out  FCNT_W  completed frames; wraps.
- PARTIAL  out  1  sticky: a frame started on timeout with LEVEL < FRAME_LEN.
- SHORT  out  1  sticky: FIFO went empty before FRAME_LEN pixels were read.

Behaviour:
- Reset values: all outputs 0, state IDLE. RST has priority over ENABLE. ENABLE=0 has the same effect as RST, except ENABLE=0 is sampled only when RST=0.
- Occupancy tracking:
  - inc = FIFO_WE & ~FIFO_FULL; dec = FIFO_RE & ~FIFO_EMPTY.
  - inc&dec leaves LEVEL unchanged. LEVEL saturates at 0 and at 2^LVL_W-1.
  - LEVEL is a registered output; it updates one cycle after the strobe.
- eff_len = (FRAME_LEN==0) ? 1 : FRAME_LEN. Sampled into pix_target on entry to RUNNING; later FRAME_LEN changes do not affect a frame in progress.
- States:
  - IDLE: enter FILL when LEVEL>0 or SW_RUN.
  - FILL: tmo counter increments each cycle while LEVEL>0; it is cleared on entry. Go to RUNNING when any of:
    - SW_RUN;
    - AUTO & LEVEL>=eff_len;
    - AUTO & TIMEOUT!=0 & tmo==TIMEOUT-1 & LEVEL>0. If LEVEL<eff_len, set PARTIAL.
    - Priority when several are true in the same cycle: SW_RUN, then fill, then timeout.
    - If SW_RUN arrives with LEVEL==0, enter RUNNING anyway: the serializer emits the reset code only.
  - RUNNING: RUN=1, registered, asserted the cycle after entry. pix_cnt increments on each dec.
    - pix_cnt reaching pix_target: go to WAIT_EOF.
    - FIFO_EMPTY high for 2 consecutive cycles with pix_cnt<pix_target: set SHORT, go to WAIT_EOF.
  - WAIT_EOF: RUN=0. On SER_EOF, FRAME_CNT += 1 (wraps at 2^FCNT_W-1 -> 0); next state is FILL if LEVEL>0, else IDLE.
    - SER_EOF in any other state is ignored.
    - SW_RUN in RUNNING or WAIT_EOF is dropped, not queued.
- PARTIAL and SHORT are sticky. They clear only on RST or ENABLE=0.
- Latency: start condition true at cycle N -> state RUNNING at N+1 -> RUN=1 at N+2.
- ENABLE deasserting mid-frame: RUN drops the next cycle, LEVEL clears to 0 (the FIFO is reset by ~ENABLE at the top level), FRAME_CNT clears.

Decomposition:
- Shared package/include holds:
  - state encodings (ST_IDLE=2'd0, ST_FILL=2'd1, ST_RUN=2'd2, ST_EOF=2'd3);
  - LVL_W/TMO_W/FCNT_W defaults;
  - the EMPTY_DEBOUNCE=2 constant.
- One sub-module: fifo_level_tracker (inc/dec saturating counter producing LEVEL). FSM and timers stay in frame_sched.

Test Plan:
- AUTO=1, FRAME_LEN=4, TIMEOUT=0; write 4 pixels; serializer reads 4 then pulses SER_EOF -> RUN rises 2 cycles after LEVEL=4; RUN falls after the 4th read; FRAME_CNT=1; state IDLE; PARTIAL=0, SHORT=0.
- AUTO=1, FRAME_LEN=8, TIMEOUT=100; write 3 pixels at once -> RUN asserts 100 cycles after the first LEVEL>0 cycle (+1 register delay); PARTIAL=1. Reads deplete at 3, empty for 2 cycles -> SHORT=1, WAIT_EOF.
- AUTO=0, FRAME_LEN=4, LEVEL=10; no SW_RUN for 500 cycles -> RUN stays 0. SW_RUN pulse -> RUN 2 cycles later; exactly 4 reads; after SER_EOF returns to FILL with LEVEL=6.
- Simultaneous FIFO_WE and FIFO_RE for 20 cycles at LEVEL=5 -> LEVEL stays 5. FIFO_WE with FIFO_FULL=1 -> no increment. FIFO_RE at LEVEL=0 -> LEVEL stays 0.
- FRAME_CNT=255 then one more complete frame -> FRAME_CNT=0. FRAME_LEN=0 -> frame ends after 1 read.
- Mid-RUNNING: ENABLE=0 for 1 cycle -> RUN=0, LEVEL=0, FRAME_CNT=0, flags 0, state IDLE next cycle. Repeat with RST=1 -> identical response.
